// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   arb_state_e : grant FSM states (IDLE arbitrates, LOCK forwards a burst)
//   req_beat_t  : one request beat at the default widths (AW=32, DW=64)
//   own_w()     : width of a requester index, never less than 1
package mem_arb_pkg;

  localparam int NREQ_DEF = 2;
  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 64;

  function automatic int own_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OWN_W = own_w(NREQ_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [AW_DEF-1:0]   addr;
    logic                write;
    logic [DW_DEF-1:0]   wdata;
    logic [DW_DEF/8-1:0] wstrb;
    logic                last;
  } req_beat_t;

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// In-order record of which requester owns each burst still awaiting its
// response. One entry is pushed per granted burst and popped on the final
// response beat of that burst.
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push, data : enqueue a requester index (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   head       : owner of the oldest outstanding burst
//   full/empty : occupancy flags
module mem_arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] store [DEPTH];
  // one extra pointer bit distinguishes full from empty
  logic [PW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // payload needs no reset: it is only read while the pointers say valid
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= data;
  end

endmodule

// File: rtl/mem_share_arbiter.sv
// Shares one memory request port between NREQ requesters.
// Round-robin grant, locked for a whole burst, with a one-cycle arbitration
// bubble in IDLE. Responses are steered back through an in-order owner FIFO.
//   clk, rst          : clock, asynchronous active-high reset
//   req_*             : per-requester request beats (flat, requester i at [i*W+:W])
//   mem_req_*         : forwarded request beat toward memory
//   mem_rsp_*         : response beats from memory
//   rsp_valid/ready   : per-requester response handshake
//   rsp_data/rsp_last : response payload broadcast to all requesters
//   owner, busy       : locked requester and lock status
//   err               : sticky, a response arrived with no outstanding burst
module mem_share_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int OWN_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*DW-1:0]     req_wdata,
  input  logic [NREQ*DW/8-1:0]   req_wstrb,
  input  logic [NREQ-1:0]        req_last,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [AW-1:0]          mem_req_addr,
  output logic                   mem_req_write,
  output logic [DW-1:0]          mem_req_wdata,
  output logic [DW/8-1:0]        mem_req_wstrb,
  output logic                   mem_req_last,
  input  logic                   mem_rsp_valid,
  output logic                   mem_rsp_ready,
  input  logic [DW-1:0]          mem_rsp_data,
  input  logic                   mem_rsp_last,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DW-1:0]          rsp_data,
  output logic                   rsp_last,
  output logic [own_w(NREQ)-1:0] owner,
  output logic                   busy,
  output logic                   err
);

  localparam int              OW       = own_w(NREQ);
  localparam int              SW       = DW/8;
  localparam logic [OW:0]     NREQ_W   = (OW+1)'(NREQ);
  localparam logic [OW-1:0]   LAST_IDX = OW'(NREQ-1);

  // flat ports viewed as per-requester lanes
  logic [NREQ-1:0][AW-1:0] addr_p;
  logic [NREQ-1:0][DW-1:0] wdata_p;
  logic [NREQ-1:0][SW-1:0] wstrb_p;
  assign addr_p  = req_addr;
  assign wdata_p = req_wdata;
  assign wstrb_p = req_wstrb;

  arb_state_e    state, state_nxt;
  logic [OW-1:0] owner_q, owner_nxt;
  logic [OW-1:0] rr_ptr, rr_nxt;
  logic          started, started_nxt;  // first beat of current burst already pushed
  logic          push, pop, full, empty, err_set;
  logic [OW-1:0] head;

  // ---------------- round-robin search ----------------
  // Rotate the valid vector so rr_ptr lands at bit 0, take the lowest set
  // bit, then map the offset back to an absolute index modulo NREQ.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [OW:0]       sum;
  logic [OW-1:0]     pick;
  logic              found;

  always_comb begin
    dbl   = {req_valid, req_valid};
    rot   = NREQ'(dbl >> rr_ptr);
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (OW+1)'(k);
        pick  = (sum >= NREQ_W) ? OW'(sum - NREQ_W) : OW'(sum);
      end
    end
  end

  // ---------------- grant FSM + request mux ----------------
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner_q;
    rr_nxt        = rr_ptr;
    started_nxt   = started;
    push          = 1'b0;
    req_ready     = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_write = 1'b0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    mem_req_last  = 1'b0;
    case (state)
      IDLE: begin
        // registered grant: nothing reaches the memory port from IDLE
        if (found && !full) begin
          owner_nxt   = pick;
          started_nxt = 1'b0;
          state_nxt   = LOCK;
        end
      end
      LOCK: begin
        mem_req_valid      = req_valid[owner_q];
        mem_req_addr       = addr_p[owner_q];
        mem_req_write      = req_write[owner_q];
        mem_req_wdata      = wdata_p[owner_q];
        mem_req_wstrb      = wstrb_p[owner_q];
        mem_req_last       = req_last[owner_q];
        req_ready[owner_q] = mem_req_ready;
        if (req_valid[owner_q] && mem_req_ready) begin
          push = ~started;
          if (req_last[owner_q]) begin
            state_nxt   = IDLE;
            started_nxt = 1'b0;
            rr_nxt      = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          end else begin
            started_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= '0;
      rr_ptr  <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner_q <= owner_nxt;
      rr_ptr  <= rr_nxt;
      started <= started_nxt;
    end
  end

  assign owner = owner_q;
  assign busy  = (state == LOCK);

  // ---------------- owner FIFO ----------------
  mem_arb_owner_fifo #(
    .DEPTH (OWN_DEPTH),
    .W     (OW)
  ) u_own_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .data  (owner_q),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // ---------------- response demux ----------------
  // Gated by rst so every output reads 0 while reset is held.
  always_comb begin
    rsp_valid     = '0;
    rsp_data      = '0;
    rsp_last      = 1'b0;
    mem_rsp_ready = 1'b0;
    pop           = 1'b0;
    err_set       = 1'b0;
    if (!rst) begin
      if (empty) begin
        // orphan beat: swallow it so memory cannot stall, and flag it
        mem_rsp_ready = mem_rsp_valid;
        err_set       = mem_rsp_valid;
      end else begin
        rsp_valid[head] = mem_rsp_valid;
        rsp_data        = mem_rsp_valid ? mem_rsp_data : '0;
        rsp_last        = mem_rsp_valid & mem_rsp_last;
        mem_rsp_ready   = rsp_ready[head];
        pop             = mem_rsp_valid & rsp_ready[head] & mem_rsp_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Scoreboard bench for mem_share_arbiter: tests push expected memory beats
// and response beats into queues; a negedge monitor pops and compares on
// every handshake.
module tb_mem_share_arbiter;
  import mem_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = DW/8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_write, req_last;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*DW-1:0]    req_wdata;
  logic [NREQ*SW-1:0]    req_wstrb;
  logic                  mem_req_valid, mem_req_ready, mem_req_write, mem_req_last;
  logic [AW-1:0]         mem_req_addr;
  logic [DW-1:0]         mem_req_wdata;
  logic [SW-1:0]         mem_req_wstrb;
  logic                  mem_rsp_valid, mem_rsp_ready, mem_rsp_last;
  logic [DW-1:0]         mem_rsp_data;
  logic [NREQ-1:0]       rsp_valid, rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic                  rsp_last;
  logic [OWN_W-1:0]      owner;
  logic                  busy, err;

  always #5 clk = ~clk;

  logic      a_valid [NREQ];
  req_beat_t a_beat  [NREQ];

  always_comb begin
    req_valid = '0; req_addr = '0; req_write = '0;
    req_wdata = '0; req_wstrb = '0; req_last = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = a_valid[i];
      req_addr[i*AW +: AW]   = a_beat[i].addr;
      req_write[i]           = a_beat[i].write;
      req_wdata[i*DW +: DW]  = a_beat[i].wdata;
      req_wstrb[i*SW +: SW]  = a_beat[i].wstrb;
      req_last[i]            = a_beat[i].last;
    end
  end

  mem_share_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .OWN_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_last(req_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_req_last(mem_req_last),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .owner(owner), .busy(busy), .err(err)
  );

  typedef struct {int lane; req_beat_t b;} exp_req_t;
  typedef struct {int lane; logic [DW-1:0] data; logic last;} exp_rsp_t;
  exp_req_t q_req[$];
  exp_rsp_t q_rsp[$];
  int       hs_cyc[$];
  int       vectors = 0;
  int       miscompares = 0;
  int       cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_beat_t mk(input int lane, input logic [31:0] addr, input bit wr, input bit last);
    req_beat_t b;
    b.addr  = addr;
    b.write = wr;
    b.wdata = {24'hD47A00, 8'(lane), addr};
    b.wstrb = wr ? 8'hFF : 8'h00;
    b.last  = last;
    return b;
  endfunction

  task automatic expect_burst(input int lane, input int n, input bit wr, input logic [31:0] base);
    exp_req_t e;
    for (int b = 0; b < n; b++) begin
      e.lane = lane;
      e.b    = mk(lane, base + 32'(8*b), wr, b == n-1);
      q_req.push_back(e);
    end
  endtask

  task automatic expect_rsp(input int lane, input logic [DW-1:0] d, input bit last);
    exp_rsp_t e;
    e.lane = lane; e.data = d; e.last = last;
    q_rsp.push_back(e);
  endtask

  // requester driver: one beat per accepted handshake, bounded wait per beat
  task automatic burst(input int lane, input int n, input bit wr, input logic [31:0] base);
    bit ok;
    int t;
    for (int b = 0; b < n; b++) begin
      a_beat[lane]  = mk(lane, base + 32'(8*b), wr, b == n-1);
      a_valid[lane] = 1'b1;
      ok = 1'b0; t = 0;
      while (!ok && t < 100) begin
        @(negedge clk);
        ok = req_ready[lane];
        @(posedge clk); #1;
        t++;
      end
      if (!ok) check("burst_timeout", 0, 1);
    end
    a_valid[lane] = 1'b0;
  endtask

  // memory response driver
  task automatic respond(input logic [DW-1:0] d, input bit last);
    bit ok;
    int t;
    mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_last = last;
    ok = 1'b0; t = 0;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = mem_rsp_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) check("rsp_timeout", 0, 1);
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    exp_req_t er;
    exp_rsp_t es;
    if (!rst && mem_req_valid && mem_req_ready) begin
      hs_cyc.push_back(cyc);
      if (q_req.size() == 0) check("req_unexpected", 1, 0);
      else begin
        er = q_req.pop_front();
        check("req_owner", owner, er.lane);
        check("req_ready_onehot", req_ready, 1 << er.lane);
        check("req_addr", mem_req_addr, er.b.addr);
        check("req_write", mem_req_write, er.b.write);
        check("req_wdata", mem_req_wdata, er.b.wdata);
        check("req_wstrb", mem_req_wstrb, er.b.wstrb);
        check("req_last", mem_req_last, er.b.last);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!rst && rsp_valid[i] && rsp_ready[i]) begin
        if (q_rsp.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          es = q_rsp.pop_front();
          check("rsp_lane", i, es.lane);
          check("rsp_onehot", rsp_valid, 1 << es.lane);
          check("rsp_data", rsp_data, es.data);
          check("rsp_last", rsp_last, es.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin a_valid[i] = 1'b0; a_beat[i] = '0; end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_last = 1'b0;
    rsp_ready = '1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_err", err, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_rsp_ready", mem_rsp_ready, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // 1: reset while locked to requester 1
    a_beat[1] = mk(1, 32'h100, 0, 0);
    a_valid[1] = 1'b1;
    for (int t = 0; t < 10 && !busy; t++) @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_owner", owner, 1);
    check("t1_mem_req_valid", mem_req_valid, 1);
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("t1_rst_busy", busy, 0);
    check("t1_rst_owner", owner, 0);
    check("t1_rst_mem_req_valid", mem_req_valid, 0);
    check("t1_rst_req_ready", req_ready, 0);
    check("t1_rst_addr", mem_req_addr, 0);
    a_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // 2: round-robin, both requesters valid with 1-beat reads; first grant to 0
    hs_cyc.delete();
    expect_burst(0, 1, 0, 32'h1000);
    expect_burst(1, 1, 0, 32'h2000);
    expect_burst(0, 1, 0, 32'h1010);
    expect_burst(1, 1, 0, 32'h2010);
    fork
      begin burst(0, 1, 0, 32'h1000); burst(0, 1, 0, 32'h1010); end
      begin burst(1, 1, 0, 32'h2000); burst(1, 1, 0, 32'h2010); end
    join
    check("t2_hs_count", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4)
      for (int k = 1; k < 4; k++) check("t2_rr_gap", hs_cyc[k] - hs_cyc[k-1], 2);
    expect_rsp(0, 64'hA0, 1); expect_rsp(1, 64'hA1, 1);
    expect_rsp(0, 64'hA2, 1); expect_rsp(1, 64'hA3, 1);
    respond(64'hA0, 1); respond(64'hA1, 1); respond(64'hA2, 1); respond(64'hA3, 1);

    // 3: burst lock, req0 4-beat write while req1 waits
    hs_cyc.delete();
    expect_burst(0, 4, 1, 32'h3000);
    expect_burst(1, 1, 0, 32'h4000);
    fork
      burst(0, 4, 1, 32'h3000);
      burst(1, 1, 0, 32'h4000);
    join
    check("t3_hs_count", hs_cyc.size(), 5);
    if (hs_cyc.size() == 5) begin
      for (int k = 1; k < 4; k++) check("t3_burst_gap", hs_cyc[k] - hs_cyc[k-1], 1);
      check("t3_regrant_gap", hs_cyc[4] - hs_cyc[3], 2);
    end
    expect_rsp(0, 64'hB0, 1); expect_rsp(1, 64'hB1, 1);
    respond(64'hB0, 1); respond(64'hB1, 1);

    // 4: ordering with delayed responses
    expect_burst(0, 4, 0, 32'h5000);
    expect_burst(1, 1, 0, 32'h6000);
    fork
      burst(0, 4, 0, 32'h5000);
      burst(1, 1, 0, 32'h6000);
    join
    repeat (20) @(posedge clk); #1;
    expect_rsp(0, 64'hC0, 0); expect_rsp(0, 64'hC1, 0);
    expect_rsp(0, 64'hC2, 0); expect_rsp(0, 64'hC3, 1);
    expect_rsp(1, 64'hC4, 1);
    respond(64'hC0, 0); respond(64'hC1, 0); respond(64'hC2, 0); respond(64'hC3, 1);
    respond(64'hC4, 1);

    // 5: owner FIFO full blocks the fifth grant until one pop
    for (int k = 0; k < 5; k++) expect_burst(0, 1, 0, 32'h7000 + 32'(16*k));
    for (int k = 0; k < 4; k++) burst(0, 1, 0, 32'h7000 + 32'(16*k));
    fork
      burst(0, 1, 0, 32'h7040);
      begin
        repeat (5) begin
          @(negedge clk);
          check("t5_full_busy", busy, 0);
          check("t5_full_ready", req_ready[0], 0);
        end
        @(posedge clk); #1;
        expect_rsp(0, 64'hD0, 1);
        respond(64'hD0, 1);
      end
    join
    for (int k = 1; k < 5; k++) expect_rsp(0, 64'hD0 + 64'(k), 1);
    for (int k = 1; k < 5; k++) respond(64'hD0 + 64'(k), 1);

    // 6: orphan response sets sticky err
    check("t6_err_before", err, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hEE; mem_rsp_last = 1'b1;
    @(negedge clk);
    check("t6_mem_rsp_ready", mem_rsp_ready, 1);
    check("t6_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
    check("t6_err_set", err, 1);
    repeat (5) @(posedge clk); #1;
    check("t6_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    check("t6_err_cleared", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("end_req_queue", q_req.size(), 0);
    check("end_rsp_queue", q_rsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
